nbout_packer: RTL



---
 rtl/nbout_packer_pkg.sv | 27 ++
 rtl/nbout_packer_if.sv | 40 ++++
 rtl/nbout_packer_line_fifo.sv | 60 ++++++
 rtl/nbout_packer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/nbout_packer_pkg.sv
// nbout_packer_pkg
// Shared defaults and width helpers for the NBout packer slice.
//   N_DEF     : neuron value width in bits
//   TN_DEF    : neuron values packed per line
//   DEPTH_DEF : line FIFO depth (power of two, >= 2)
//   idx_w()   : width of a lane index (0..TN-1)
//   lanes_w() : width of a lane count (0..TN)
//   cnt_w()   : width of a FIFO occupancy count (0..DEPTH)
package nbout_packer_pkg;

  localparam int N_DEF     = 16;
  localparam int TN_DEF    = 16;
  localparam int DEPTH_DEF = 4;

  function automatic int idx_w(input int tn);
    return (tn > 1) ? $clog2(tn) : 1;
  endfunction

  function automatic int lanes_w(input int tn);
    return $clog2(tn + 1);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nbout_packer_if.sv
// nbout_packer_if
// Bundles the neuron input handshake and the line output handshake.
//   i_Y / i_Y_valid / o_Y_ready : one neuron value per cycle from n3
//   i_flush                     : commit the partially filled line
//   o_line / o_line_lanes       : head-of-FIFO line and its valid lane count
//   o_line_valid / i_line_ready : line handshake towards NBout
//   o_count                     : lines currently queued
// slave is the packer side, master is the producer/consumer side.
interface nbout_packer_if
  import nbout_packer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int TN    = TN_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();

  localparam int LW = lanes_w(TN);
  localparam int CW = cnt_w(DEPTH);

  logic [N-1:0]    i_Y;
  logic            i_Y_valid;
  logic            o_Y_ready;
  logic            i_flush;
  logic [TN*N-1:0] o_line;
  logic [LW-1:0]   o_line_lanes;
  logic            o_line_valid;
  logic            i_line_ready;
  logic [CW-1:0]   o_count;

  modport slave (
    input  i_Y, i_Y_valid, i_flush, i_line_ready,
    output o_Y_ready, o_line, o_line_lanes, o_line_valid, o_count
  );

  modport master (
    output i_Y, i_Y_valid, i_flush, i_line_ready,
    input  o_Y_ready, o_line, o_line_lanes, o_line_valid, o_count
  );

endinterface

// File: rtl/nbout_packer_line_fifo.sv
// nbout_packer_line_fifo
// Synchronous FIFO holding packed lines (line data plus lane count).
//   clk, rst   : clock and synchronous active-high reset (clears storage too)
//   push       : write push_data at the tail (caller guarantees not full)
//   push_data  : entry to write
//   pop        : drop the head entry (caller guarantees not empty)
//   head       : entry at the read pointer
//   count      : number of entries queued
module nbout_packer_line_fifo
  import nbout_packer_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            head,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^PW).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      cnt    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {W{1'b0}};
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/nbout_packer.sv
// nbout_packer
// Packs TN consecutive N-bit output neurons into one line and queues lines
// in a DEPTH-entry FIFO for write-back to NBout. A flush commits a partially
// filled, zero-padded line at the end of a layer.
//   clk, rst : clock and synchronous active-high reset
//   bus      : nbout_packer_if.slave (neuron input, flush, line output, count)
module nbout_packer
  import nbout_packer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int TN    = TN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  nbout_packer_if.slave  bus
);

  localparam int IW = idx_w(TN);
  localparam int LW = lanes_w(TN);
  localparam int CW = cnt_w(DEPTH);
  localparam int LN = TN * N;
  localparam int W  = LN + LW;

  logic [IW-1:0] lane_cnt;
  logic [IW-1:0] lane_nxt;
  logic [LN-1:0] asm_line;
  logic [LN-1:0] asm_nxt;
  logic [LN-1:0] asm_ins;
  logic          flush_pending;
  logic          fp_nxt;

  logic          full;
  logic          ready;
  logic          accept;
  logic          last;
  logic          flush_req;
  logic [LW-1:0] lanes_now;

  logic          push;
  logic [W-1:0]  push_data;
  logic          pop;
  logic          line_valid;
  logic [W-1:0]  head;
  logic [CW-1:0] fcount;

  // Ready depends only on registered state, never on i_line_ready.
  assign full      = (fcount == CW'(DEPTH));
  assign ready     = !full && !flush_pending;
  assign accept    = bus.i_Y_valid && ready;
  assign last      = accept && (lane_cnt == IW'(TN - 1));
  assign lanes_now = LW'(lane_cnt) + (accept ? LW'(1) : LW'(0));
  // A pending flush keeps retrying until the FIFO has room.
  assign flush_req = (bus.i_flush || flush_pending) && (lanes_now != LW'(0));

  // Assembly line with the accepted value (if any) dropped into its lane.
  always_comb begin
    asm_ins = asm_line;
    for (int k = 0; k < TN; k++) begin
      if (accept && (lane_cnt == IW'(k))) begin
        asm_ins[k*N +: N] = bus.i_Y;
      end else begin
        asm_ins[k*N +: N] = asm_line[k*N +: N];
      end
    end
  end

  // Push decision: a completed line wins (and satisfies a same-cycle flush),
  // otherwise a flush pushes the partial line or waits for room.
  always_comb begin
    push      = 1'b0;
    push_data = {W{1'b0}};
    lane_nxt  = lane_cnt;
    asm_nxt   = asm_line;
    fp_nxt    = flush_pending;
    if (last) begin
      push      = 1'b1;
      push_data = {LW'(TN), asm_ins};
      lane_nxt  = {IW{1'b0}};
      asm_nxt   = {LN{1'b0}};
      fp_nxt    = 1'b0;
    end else if (flush_req) begin
      if (!full) begin
        push      = 1'b1;
        push_data = {lanes_now, asm_ins};
        lane_nxt  = {IW{1'b0}};
        asm_nxt   = {LN{1'b0}};
        fp_nxt    = 1'b0;
      end else begin
        fp_nxt    = 1'b1;
        asm_nxt   = asm_ins;
        lane_nxt  = accept ? (lane_cnt + IW'(1)) : lane_cnt;
      end
    end else if (accept) begin
      asm_nxt  = asm_ins;
      lane_nxt = lane_cnt + IW'(1);
    end else begin
      asm_nxt  = asm_line;
      lane_nxt = lane_cnt;
    end
  end

  // Lane counter, assembly register and deferred-flush flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt      <= {IW{1'b0}};
      asm_line      <= {LN{1'b0}};
      flush_pending <= 1'b0;
    end else begin
      lane_cnt      <= lane_nxt;
      asm_line      <= asm_nxt;
      flush_pending <= fp_nxt;
    end
  end

  assign line_valid = (fcount != CW'(0));
  assign pop        = line_valid && bus.i_line_ready;

  nbout_packer_line_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fcount)
  );

  assign bus.o_Y_ready    = ready;
  assign bus.o_line       = head[LN-1:0];
  assign bus.o_line_lanes = head[W-1 -: LW];
  assign bus.o_line_valid = line_valid;
  assign bus.o_count      = fcount;

endmodule
